instr_mem_resp: RTL and testbench
=================================

INSTR_MEM_RESP -- requirements
Module: instr_mem_resp

Interface
REQ-001 Parameter LATENCY, default 2, the number of cycles from request acceptance to done; legal range 1-7.
REQ-002 Parameter DEPTH_LOG2, default 10, the log2 of the number of 16-bit words in the array.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 rd  input  1  fetch request valid.
REQ-006 addr  input  16  byte address of the requested instruction.
REQ-007 abort  input  1  branch redirect from fetch; cancels any in-flight request.
REQ-008 wr_en  input  1  preload/bootloader word write enable.
REQ-009 wr_addr  input  16  byte address for the preload write.
REQ-010 wr_data  input  16  preload write data.
REQ-011 instr  output  16  returned instruction; valid only while done=1.
REQ-012 done  output  1  one-cycle pulse marking instr valid.
REQ-013 stall  output  1  high while a request is in flight; fetch holds PC.
REQ-014 err  output  1  misaligned-request flag, valid with done.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 In IDLE, rd=1 SHALL accept the request, latch word index addr[DEPTH_LOG2:1] and snapshot array data.
REQ-017 On acceptance, the FSM SHALL load the counter with LATENCY-1 and enter BUSY; if LATENCY=1, it SHALL enter DONE directly.
REQ-018 A request accepted in cycle T SHALL raise done in cycle T+LATENCY, for exactly one cycle.
REQ-019 stall SHALL be 1 in every BUSY cycle and 0 in IDLE and DONE.
REQ-020 In BUSY, the counter SHALL decrement each cycle, and the FSM SHALL enter DONE when it moves from 1 to 0.
REQ-021 The counter SHALL be 3 bits wide and SHALL never wrap below 0.
REQ-022 In DONE, the FSM SHALL accept rd=1 as a back-to-back request (per REQ-016/017); otherwise it SHALL return to IDLE.
REQ-023 abort=1 in BUSY SHALL drop the in-flight request with no done pulse and then apply REQ-016 to the same cycle's rd/addr; with rd=0 it SHALL go to IDLE.
REQ-024 abort=1 in DONE SHALL NOT suppress the current done pulse.
REQ-025 abort=1 in IDLE SHALL have no effect.
REQ-026 rd in BUSY without abort SHALL be ignored.
REQ-027 Address bits above DEPTH_LOG2 SHALL be ignored, so addresses wrap modulo the array size.
REQ-028 Read data SHALL be the snapshot taken at acceptance; a write in the acceptance cycle itself SHALL be visible (write-first).
REQ-029 Writes after acceptance SHALL NOT alter the pending instr.
REQ-030 wr_en SHALL write wr_data to word wr_addr[DEPTH_LOG2:1] in any state, one write per cycle.
REQ-031 instr SHALL hold its last value outside DONE.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, counter=0, done=0, stall=0, err=0 and instr=16'h0000, with priority over all other inputs.
REQ-033 Reset during BUSY or DONE SHALL discard the request, and no done pulse SHALL follow.
REQ-034 Array contents SHALL NOT be reset.
REQ-035 A wr_en write in a reset cycle SHALL still be performed.

Configuration
REQ-036 Macro IMEM_ALIGN_CHECK_EN defined: err SHALL equal the latched addr[0] during done and be 0 otherwise, and instr SHALL still return word data.
REQ-037 Macro IMEM_ALIGN_CHECK_EN undefined: err SHALL be tied to 0 and addr[0] SHALL be ignored.

Verification
REQ-038 Preload word 0x0010=16'hA5C3, LATENCY=2, rd with addr=0x0010 at T -> stall=1 at T+1, done=1 and instr=A5C3 at T+2, stall=0.
REQ-039 LATENCY=1, rd held high with addr 0x0000, 0x0002, 0x0004 -> done every cycle from T+1, returning words 0, 1 and 2 in order.
REQ-040 LATENCY=3, rd addr=0x0020 at T, abort with rd addr=0x0040 at T+1 -> no done at T+3, done with word 0x0040's data at T+4.
REQ-041 LATENCY=2, rd at T, wr_en to the same word at T+1 with 16'hFFFF -> done at T+2 returns the old data.
REQ-042 rst at T+1 of an in-flight request -> all outputs 0 from T+2 and no done pulse; a preloaded word still reads correctly afterward.
REQ-043 IMEM_ALIGN_CHECK_EN defined, rd addr=0x0011 -> err=1 with done; with the macro undefined, the same stimulus gives err=0.

Source files
------------

// File: rtl/instr_mem_resp.sv
// rtl/instr_mem_resp.sv - instruction word memory with fixed-latency fetch response
// Optional misaligned-fetch flag enabled by defining IMEM_ALIGN_CHECK_EN.
module instr_mem_resp #(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic [15:0] addr,
  input  logic        abort,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic [15:0] instr,
  output logic        done,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] LOAD = 3'(LATENCY - 1);

  state_t                state, state_next;
  logic [2:0]            cnt;
  logic                  accept;
  logic [15:0]           mem [0:(1 << DEPTH_LOG2) - 1];
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
  logic [15:0]           rd_word;
  logic [15:0]           snap;
  logic                  snap_odd;

  assign rd_idx = addr[DEPTH_LOG2:1];
  assign wr_idx = wr_addr[DEPTH_LOG2:1];
  // Same-cycle write to the fetched word is forwarded into the snapshot.
  assign rd_word = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: accept = rd;
      BUSY: begin
        if (abort) begin
          accept     = rd;
          state_next = IDLE;
        end else if (cnt <= 3'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        accept     = rd;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (accept)
      state_next = (LATENCY == 1) ? DONE : BUSY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 3'd0;
      instr    <= 16'h0000;
      snap     <= 16'h0000;
      snap_odd <= 1'b0;
    end else begin
      if (accept) begin
        cnt      <= LOAD;
        snap     <= rd_word;
        snap_odd <= addr[0];
      end else if ((state == BUSY) && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end
      // instr only changes on entry to DONE, so it holds elsewhere.
      if (state_next == DONE)
        instr <= accept ? rd_word : snap;
    end
  end

  assign done  = (state == DONE);
  assign stall = (state == BUSY);

`ifdef IMEM_ALIGN_CHECK_EN
  assign err = done & snap_odd;
`else
  assign err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{addr[15:DEPTH_LOG2+1], addr[0], wr_addr[15:DEPTH_LOG2+1],
                         wr_addr[0], snap_odd};

endmodule

// File: tb/tb_instr_mem_resp.sv
// tb/tb_instr_mem_resp.sv - randomized self-checking bench for instr_mem_resp
// Runs LATENCY 1, 2 and 3 side by side against a transaction-level model.
module tb_instr_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd, abort, wr_en;
  logic [15:0] addr, wr_addr, wr_data;
  logic [15:0] instr_o [3];
  logic        done_o  [3];
  logic        stall_o [3];
  logic        err_o   [3];

`ifdef IMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  instr_mem_resp #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .rd(rd), .addr(addr), .abort(abort), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .instr(instr_o[0]), .done(done_o[0]),
    .stall(stall_o[0]), .err(err_o[0]));
  instr_mem_resp #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .rd(rd), .addr(addr), .abort(abort), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .instr(instr_o[1]), .done(done_o[1]),
    .stall(stall_o[1]), .err(err_o[1]));
  instr_mem_resp #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .rd(rd), .addr(addr), .abort(abort), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .instr(instr_o[2]), .done(done_o[2]),
    .stall(stall_o[2]), .err(err_o[2]));

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: one pending fetch per instance, due at an absolute cycle number.
  logic [15:0] mem_m [1024];
  bit          pv    [3];
  int          due   [3];
  logic [15:0] pdata [3];
  logic [15:0] last  [3];
  bit          perr  [3];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      bit dn, busy;
      dn   = pv[k] && (due[k] == cyc);
      busy = pv[k] && (due[k] > cyc);
      check($sformatf("L%0d done", k + 1), {15'd0, done_o[k]}, {15'd0, dn});
      check($sformatf("L%0d stall", k + 1), {15'd0, stall_o[k]}, {15'd0, busy});
      check($sformatf("L%0d instr", k + 1), instr_o[k], dn ? pdata[k] : last[k]);
      check($sformatf("L%0d err", k + 1), {15'd0, err_o[k]}, {15'd0, dn && perr[k] && ALIGN});
    end
  endtask

  task automatic step();
    logic [9:0]  ridx, widx;
    logic [15:0] wv;
    ridx = addr[10:1];
    widx = wr_addr[10:1];
    wv   = (wr_en && (widx == ridx)) ? wr_data : mem_m[ridx];
    for (int k = 0; k < 3; k++) begin
      bit dn, busy;
      dn   = pv[k] && (due[k] == cyc);
      busy = pv[k] && (due[k] > cyc);
      if (dn) last[k] = pdata[k];
      if (rst) begin
        pv[k]   = 1'b0;
        last[k] = 16'h0000;
      end else if (rd && (!pv[k] || dn || (busy && abort))) begin
        pv[k]    = 1'b1;
        due[k]   = cyc + k + 1;
        pdata[k] = wv;
        perr[k]  = addr[0];
      end else if (dn || (busy && abort)) begin
        pv[k] = 1'b0;
      end
    end
    if (wr_en) mem_m[widx] = wr_data;
    cyc++;
  endtask

  task automatic go(input bit r_rst, input bit r_rd, input logic [15:0] r_addr,
                    input bit r_abort, input bit r_wen, input logic [15:0] r_waddr,
                    input logic [15:0] r_wdata);
    rst = r_rst; rd = r_rd; addr = r_addr; abort = r_abort;
    wr_en = r_wen; wr_addr = r_waddr; wr_data = r_wdata;
    step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    go(1, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    go(1, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 64; i++) go(0, 0, 16'h0, 0, 1, 16'(i * 2), 16'($urandom));
    go(0, 0, 16'h0, 0, 1, 16'h0010, 16'hA5C3);

    // Basic LATENCY=2 fetch
    go(0, 1, 16'h0010, 0, 0, 16'h0, 16'h0);
    check("r038 stall", {15'd0, stall_o[1]}, 16'd1);
    idle(1);
    check("r038 done", {15'd0, done_o[1]}, 16'd1);
    check("r038 instr", instr_o[1], 16'hA5C3);
    check("r038 stall0", {15'd0, stall_o[1]}, 16'd0);
    idle(4);

    // LATENCY=1 back-to-back stream
    go(0, 1, 16'h0000, 0, 0, 16'h0, 16'h0);
    check("r039 w0", instr_o[0], mem_m[0]);
    go(0, 1, 16'h0002, 0, 0, 16'h0, 16'h0);
    check("r039 w1", instr_o[0], mem_m[1]);
    go(0, 1, 16'h0004, 0, 0, 16'h0, 16'h0);
    check("r039 w2", instr_o[0], mem_m[2]);
    check("r039 done", {15'd0, done_o[0]}, 16'd1);
    idle(4);

    // LATENCY=3 abort with redirect
    go(0, 1, 16'h0020, 0, 0, 16'h0, 16'h0);
    go(0, 1, 16'h0040, 1, 0, 16'h0, 16'h0);
    idle(1);
    check("r040 nodone", {15'd0, done_o[2]}, 16'd0);
    idle(1);
    check("r040 done", {15'd0, done_o[2]}, 16'd1);
    check("r040 instr", instr_o[2], mem_m[32]);
    idle(4);

    // Write after acceptance does not disturb the pending word
    go(0, 1, 16'h0010, 0, 0, 16'h0, 16'h0);
    go(0, 0, 16'h0, 0, 1, 16'h0010, 16'hFFFF);
    check("r041 done", {15'd0, done_o[1]}, 16'd1);
    check("r041 old", instr_o[1], 16'hA5C3);
    idle(4);

    // Reset mid-flight
    go(0, 1, 16'h0010, 0, 0, 16'h0, 16'h0);
    go(1, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    check("r042 done", {15'd0, done_o[1]}, 16'd0);
    check("r042 stall", {15'd0, stall_o[2]}, 16'd0);
    check("r042 instr", instr_o[1], 16'h0000);
    idle(1);
    check("r042 nodone", {15'd0, done_o[2]}, 16'd0);
    go(0, 1, 16'h0010, 0, 0, 16'h0, 16'h0);
    idle(1);
    check("r042 reread", instr_o[1], 16'hFFFF);
    idle(4);

    // Misaligned fetch
    go(0, 1, 16'h0011, 0, 0, 16'h0, 16'h0);
    idle(1);
    check("r043 done", {15'd0, done_o[1]}, 16'd1);
    check("r043 err", {15'd0, err_o[1]}, {15'd0, ALIGN});
    check("r043 instr", instr_o[1], 16'hFFFF);
    idle(4);

    // Random traffic; upper address bits are random to exercise wrap
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a, wa;
      a      = 16'($urandom);
      a[10:1] = 10'($urandom_range(0, 63));
      wa     = 16'($urandom);
      wa[10:1] = 10'($urandom_range(0, 63));
      go($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 4, a,
         $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, wa, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
